// File: rtl/demultiplexer_core.sv
// 1-to-OUT_LEN single-bit demultiplexer: data_i is steered onto line select_i, all other lines 0.
// Optional registered output stage enabled by defining DEMULTIPLEXER_CORE_REG_OUT_EN.
module demultiplexer_core #(
    parameter int OUT_LEN = 128
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       data_i,
    input  logic [$clog2(OUT_LEN)-1:0] select_i,
    output logic [OUT_LEN-1:0]         wire_o
);

    localparam int SEL_W = $clog2(OUT_LEN);

    logic [OUT_LEN-1:0] wire_d;

    // Each line matches exactly one index, so selects at or beyond OUT_LEN
    // (non-power-of-2 widths) match no line and the output stays all zero.
    for (genvar k = 0; k < OUT_LEN; k++) begin : g_line
        assign wire_d[k] = data_i & (select_i == SEL_W'(k));
    end

`ifdef DEMULTIPLEXER_CORE_REG_OUT_EN
    logic [OUT_LEN-1:0] wire_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wire_q <= '0;
        end else begin
            wire_q <= wire_d;
        end
    end

    assign wire_o = wire_q;
`else
    // Clock and reset only serve the registered variant.
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk_i, arst_ni};

    assign wire_o = wire_d;
`endif

endmodule

// File: tb/tb_demultiplexer_core.sv
// Self-checking bench for demultiplexer_core: OUT_LEN=128 and OUT_LEN=5 instances against a
// behavioural model; follows DEMULTIPLEXER_CORE_REG_OUT_EN for the one-cycle-latency variant.
module tb_demultiplexer_core;

`ifdef DEMULTIPLEXER_CORE_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic         clk;
    logic         arst_n;
    logic         data;
    logic [6:0]   sel;
    logic [127:0] wire_big;
    logic         data5;
    logic [2:0]   sel5;
    logic [4:0]   wire5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];

    demultiplexer_core #(.OUT_LEN(128)) u_dut (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .data_i  (data),
        .select_i(sel),
        .wire_o  (wire_big)
    );

    demultiplexer_core #(.OUT_LEN(5)) u_dut5 (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .data_i  (data5),
        .select_i(sel5),
        .wire_o  (wire5)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a single line of index s carries d, everything else is zero.
    function automatic logic [127:0] model128(input logic d, input int s);
        logic [127:0] r;
        r = '0;
        if (s >= 0 && s < 128) r[s] = d;
        return r;
    endfunction

    function automatic logic [4:0] model5(input logic d, input int s);
        logic [4:0] r;
        r = '0;
        if (s >= 0 && s < 5) r[s] = d;
        return r;
    endfunction

    // Driver tasks
    task automatic drive(input logic d, input int s);
        data = d;
        sel  = 7'(s);
    endtask

    task automatic drive5(input logic d, input int s);
        data5 = d;
        sel5  = 3'(s);
    endtask

    // Wait until the outputs reflect the inputs driven just before the call.
    task automatic settle();
        if (LAT == 1) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [127:0] exp_big;
        logic [4:0]   exp5;
        arst_n = 1'b0;
        drive(1'b1, 10);
        drive5(1'b1, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_big = (LAT == 1) ? '0 : model128(1'b1, 10);
        exp5    = (LAT == 1) ? '0 : model5(1'b1, 2);
        n_checks++;
        if (wire_big !== exp_big) begin
            n_fail++;
            $display("FAIL reset_big: got %h expected %h", wire_big, exp_big);
        end
        n_checks++;
        if (wire5 !== exp5) begin
            n_fail++;
            $display("FAIL reset_5: got %b expected %b", wire5, exp5);
        end
        arst_n = 1'b1;
        drive(1'b1, 3);
        #1;
        exp_big = (LAT == 1) ? '0 : model128(1'b1, 3);
        n_checks++;
        if (wire_big !== exp_big) begin
            n_fail++;
            $display("FAIL release_before_edge: got %h expected %h", wire_big, exp_big);
        end
        settle();
        exp_big = model128(1'b1, 3);
        n_checks++;
        if (wire_big !== exp_big) begin
            n_fail++;
            $display("FAIL first_capture: got %h expected %h", wire_big, exp_big);
        end
    endtask

    task automatic test_corners();
        int           sels[6];
        logic         ds[6];
        logic [127:0] exp_big;
        sels = '{0, 127, 37, 127, 64, 1};
        ds   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(ds[i], sels[i]);
            settle();
            exp_big = model128(ds[i], sels[i]);
            n_checks++;
            if (wire_big !== exp_big) begin
                n_fail++;
                $display("FAIL corner d=%0b sel=%0d: got %h expected %h",
                         ds[i], sels[i], wire_big, exp_big);
            end
        end
    endtask

    task automatic test_sweep();
        logic [127:0] exp_big;
        for (int s = 0; s < 128; s++) begin
            drive(1'b1, s);
            settle();
            exp_big = model128(1'b1, s);
            n_checks++;
            if (wire_big !== exp_big) begin
                n_fail++;
                $display("FAIL sweep sel=%0d: got %h expected %h", s, wire_big, exp_big);
            end
            n_checks++;
            if ($countones(wire_big) !== 1) begin
                n_fail++;
                $display("FAIL sweep_onehot sel=%0d: got %0d ones expected 1",
                         s, $countones(wire_big));
            end
        end
    endtask

    task automatic test_odd_len();
        logic [4:0] exp5;
        for (int s = 0; s < 8; s++) begin
            for (int d = 0; d < 2; d++) begin
                drive5(d[0], s);
                settle();
                exp5 = model5(d[0], s);
                n_checks++;
                if (wire5 !== exp5) begin
                    n_fail++;
                    $display("FAIL len5 d=%0d sel=%0d: got %b expected %b", d, s, wire5, exp5);
                end
            end
        end
    endtask

    // Random stream: new inputs every cycle, expectations flow through exp_q.
    task automatic test_random(input int n);
        logic [127:0] exp_big;
        logic         d;
        int           s;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            d = 1'($urandom_range(1, 0));
            s = $urandom_range(127, 0);
            drive(d, s);
            exp_q.push_back(model128(d, s));
            @(negedge clk);
            if (exp_q.size() > LAT) begin
                exp_big = exp_q.pop_front();
                n_checks++;
                if (wire_big !== exp_big) begin
                    n_fail++;
                    $display("FAIL random cycle=%0d: got %h expected %h", i, wire_big, exp_big);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [127:0] exp_big;
        logic [4:0]   exp5;
        drive(1'b1, 3);
        drive5(1'b1, 4);
        settle();
        exp_big = model128(1'b1, 3);
        n_checks++;
        if (wire_big !== exp_big) begin
            n_fail++;
            $display("FAIL pre_mid_reset: got %h expected %h", wire_big, exp_big);
        end
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        exp_big = (LAT == 1) ? '0 : model128(1'b1, 3);
        exp5    = (LAT == 1) ? '0 : model5(1'b1, 4);
        n_checks++;
        if (wire_big !== exp_big) begin
            n_fail++;
            $display("FAIL mid_reset_big: got %h expected %h", wire_big, exp_big);
        end
        n_checks++;
        if (wire5 !== exp5) begin
            n_fail++;
            $display("FAIL mid_reset_5: got %b expected %b", wire5, exp5);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0;
        drive(1'b0, 0);
        drive5(1'b0, 0);
        test_reset();
        test_corners();
        test_sweep();
        test_odd_len();
        test_random(20000);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
